// File: rtl/cpu_inf_pkg.sv
// Shared constants for the CPU register-space router: slot map, read FSM encodings,
// default bus geometry and the block version word.
package cpu_inf_pkg;

    localparam int C_DEF_DATA_W  = 32;
    localparam int C_DEF_ADDR_W  = 12;
    localparam int C_DEF_N_SLOTS = 5;

    // Slot select values of the peripheral register banks behind the router
    localparam int C_COMMON_BASE = 0;
    localparam int C_GPIO_BASE   = 1;
    localparam int C_PWM_BASE    = 2;
    localparam int C_I2C_BASE    = 3;
    localparam int C_SPI_BASE    = 4;

    localparam logic [31:0] C_VERSION = 32'h0001_0000;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t S_IDLE = 2'd0;
    localparam rd_state_t S_WAIT = 2'd1;
    localparam rd_state_t S_RESP = 2'd2;

endpackage

// File: rtl/cpu_inf_router_if.sv
// Bus bundle between the AXI-lite slave shell, the router and the slot register banks.
// The slave modport is the router's view; master is the shell/bank side.
interface cpu_inf_router_if
    import cpu_inf_pkg::*;
#(
    parameter int DW = C_DEF_DATA_W,
    parameter int AW = C_DEF_ADDR_W,
    parameter int NS = C_DEF_N_SLOTS
);
    logic [AW-1:0]    S_AXI_AWADDR;
    logic [AW-1:0]    S_AXI_ARADDR;
    logic             slv_reg_wren;
    logic             slv_reg_rden;
    logic [NS-1:0]    slot_wren;
    logic [NS-1:0]    slot_rden;
    logic [NS-1:0]    slot_rack;
    logic [NS*DW-1:0] slot_rdata;
    logic [DW-1:0]    S_AXI_RDATA;
    logic             rd_done;
    logic             rd_err;
    logic             wr_err;
    logic             rd_busy;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_ARADDR, slv_reg_wren, slv_reg_rden, slot_rack, slot_rdata,
        output slot_wren, slot_rden, S_AXI_RDATA, rd_done, rd_err, wr_err, rd_busy
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_ARADDR, slv_reg_wren, slv_reg_rden, slot_rack, slot_rdata,
        input  slot_wren, slot_rden, S_AXI_RDATA, rd_done, rd_err, wr_err, rd_busy
    );

endinterface

// File: rtl/cpu_inf_rd_fsm.sv
// Read sequencer: issues a one-cycle slot read strobe, waits a bounded number of
// cycles for the selected slot's acknowledge, then reports data and status.
module cpu_inf_rd_fsm
    import cpu_inf_pkg::*;
#(
    parameter int DW      = 32,
    parameter int SEL_W   = 4,
    parameter int N_SLOTS = 5,
    parameter int TIMEOUT = 15
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_rden,
    input  logic               i_mapped,
    input  logic [SEL_W-1:0]   i_sel,
    input  logic               i_rack,
    input  logic [DW-1:0]      i_rdata,
    output logic [SEL_W-1:0]   o_sel_q,
    output logic [N_SLOTS-1:0] o_slot_rden,
    output logic [DW-1:0]      o_rdata,
    output logic               o_done,
    output logic               o_err,
    output logic               o_busy,
    output logic               o_drop
);

    rd_state_t          r_state;
    logic [7:0]         r_cnt;
    logic [SEL_W-1:0]   r_sel;
    logic [N_SLOTS-1:0] r_slot_rden;
    logic [DW-1:0]      r_rdata;
    logic               r_err;
    logic               r_done;
    logic               r_rd_err;

    // An acknowledge arriving in the final permitted wait cycle still counts as success
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sel       <= '0;
            r_slot_rden <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_rd_err    <= 1'b0;
        end else begin
            r_slot_rden <= '0;
            r_done      <= 1'b0;
            r_rd_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (i_rden) begin
                        if (i_mapped) begin
                            r_sel       <= i_sel;
                            r_slot_rden <= N_SLOTS'(1) << i_sel;
                            r_state     <= S_WAIT;
                        end else begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_rack) begin
                        r_rdata <= i_rdata;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_done   <= 1'b1;
                    r_rd_err <= r_err;
                    r_cnt    <= '0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_sel_q     = r_sel;
    assign o_slot_rden = r_slot_rden;
    assign o_rdata     = r_rdata;
    assign o_done      = r_done;
    assign o_err       = r_rd_err;
    assign o_busy      = (r_state != S_IDLE);
    assign o_drop      = i_rden & o_busy;

endmodule

// File: rtl/cpu_inf_router.sv
// AXI-lite register-space router: slot decode, write fan-out, read data mux and status.
// Define CPU_INF_ERR_CNT_EN to add the saturating err_cnt / err_cnt_clr error counter.
module cpu_inf_router
    import cpu_inf_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = C_DEF_DATA_W,
    parameter int C_S_AXI_ADDR_WIDTH = C_DEF_ADDR_W,
    parameter int SLOT_LSB           = 8,
    parameter int SEL_W              = 4,
    parameter int N_SLOTS            = C_DEF_N_SLOTS,
    parameter int TIMEOUT            = 15
)(
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESETN,
`ifdef CPU_INF_ERR_CNT_EN
    input  logic                   err_cnt_clr,
    output logic [15:0]            err_cnt,
`endif
    cpu_inf_router_if.slave        bus
);

    localparam int DW = C_S_AXI_DATA_WIDTH;

    logic [SEL_W-1:0]   w_wr_sel;
    logic [SEL_W-1:0]   w_rd_sel;
    logic [SEL_W-1:0]   w_sel_q;
    logic               w_wr_mapped;
    logic               w_rd_mapped;
    logic               w_rack;
    logic [DW-1:0]      w_rdata_mux;
    logic [N_SLOTS-1:0] w_slot_rden;
    logic [DW-1:0]      w_rdata;
    logic               w_rd_done;
    logic               w_rd_err;
    logic               w_busy;
    logic               w_drop;
    logic               r_wr_err;
    logic               w_unused;

    assign w_wr_sel    = bus.S_AXI_AWADDR[SLOT_LSB +: SEL_W];
    assign w_rd_sel    = bus.S_AXI_ARADDR[SLOT_LSB +: SEL_W];
    assign w_wr_mapped = int'(w_wr_sel) < N_SLOTS;
    assign w_rd_mapped = int'(w_rd_sel) < N_SLOTS;

    assign bus.slot_wren = (bus.slv_reg_wren && w_wr_mapped) ? (N_SLOTS'(1) << w_wr_sel) : '0;

    // Only the slot latched for the current read may acknowledge it
    assign w_rack      = |(bus.slot_rack & (N_SLOTS'(1) << w_sel_q));
    assign w_rdata_mux = bus.slot_rdata[int'(w_sel_q) * DW +: DW];

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= bus.slv_reg_wren & ~w_wr_mapped;
        end
    end

    cpu_inf_rd_fsm #(
        .DW      (DW),
        .SEL_W   (SEL_W),
        .N_SLOTS (N_SLOTS),
        .TIMEOUT (TIMEOUT)
    ) u_rd_fsm (
        .clk         (S_AXI_ACLK),
        .rst_n       (S_AXI_ARESETN),
        .i_rden      (bus.slv_reg_rden),
        .i_mapped    (w_rd_mapped),
        .i_sel       (w_rd_sel),
        .i_rack      (w_rack),
        .i_rdata     (w_rdata_mux),
        .o_sel_q     (w_sel_q),
        .o_slot_rden (w_slot_rden),
        .o_rdata     (w_rdata),
        .o_done      (w_rd_done),
        .o_err       (w_rd_err),
        .o_busy      (w_busy),
        .o_drop      (w_drop)
    );

    assign bus.slot_rden   = w_slot_rden;
    assign bus.S_AXI_RDATA = w_rdata;
    assign bus.rd_done     = w_rd_done;
    assign bus.rd_err      = w_rd_err;
    assign bus.wr_err      = r_wr_err;
    assign bus.rd_busy     = w_busy;

`ifdef CPU_INF_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic [16:0] w_err_sum;

    // Several error events may land in one cycle; all are counted, saturating at all-ones
    assign w_err_sum = {1'b0, r_err_cnt} + 17'(w_rd_err) + 17'(r_wr_err) + 17'(w_drop);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_err_cnt <= '0;
        end else if (err_cnt_clr) begin
            r_err_cnt <= '0;
        end else if (w_err_sum[16]) begin
            r_err_cnt <= 16'hFFFF;
        end else begin
            r_err_cnt <= w_err_sum[15:0];
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign w_unused = ^{bus.S_AXI_AWADDR, bus.S_AXI_ARADDR, w_drop};

endmodule
